alu_share_arbiter: RTL

- Shares one 16-bit ALU datapath (AND/OR/ADD/SUB/SLT/NOR/XOR/PASS) between two requesters, e.g. the EX stage and a multi-cycle address/branch helper.
- Arbitrates round-robin, issues one operation per cycle, and registers the result into a single output slot with valid/ready back-pressure.
- Sits between the requesters and the combinational ALU core. It is the only block that drives the ALU operands.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu16_core.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, opcodes, slot state.
package alu_pkg;

    localparam int unsigned W_DEF   = 16;
    localparam int unsigned OPW_DEF = 3;

    localparam logic [OPW_DEF-1:0] OP_AND  = 3'b000;
    localparam logic [OPW_DEF-1:0] OP_OR   = 3'b001;
    localparam logic [OPW_DEF-1:0] OP_ADD  = 3'b010;
    localparam logic [OPW_DEF-1:0] OP_SUB  = 3'b011;
    localparam logic [OPW_DEF-1:0] OP_SLT  = 3'b100;
    localparam logic [OPW_DEF-1:0] OP_NOR  = 3'b101;
    localparam logic [OPW_DEF-1:0] OP_XOR  = 3'b110;
    localparam logic [OPW_DEF-1:0] OP_PASS = 3'b111;

    typedef enum logic {StEmpty, StFull} slot_state_e;

    // The result slot can take a new result when empty, or when its current
    // result is being drained on this same edge (gives 1 op/cycle throughput).
    function automatic logic slot_free(input logic rsp_valid, input logic rsp_ready);
        return ~rsp_valid | rsp_ready;
    endfunction

endpackage

// File: rtl/alu16_core.sv
// Purely combinational ALU: logic ops, wrapping add/sub with signed overflow, signed SLT.
module alu16_core
    import alu_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned OPW = OPW_DEF
) (
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   rs,
    input  logic [W-1:0]   rt,
    output logic [W-1:0]   data,
    output logic           zero,
    output logic           ovf
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         lt;

    always_comb begin
        sum  = rs + rt;
        diff = rs - rt;
        lt   = $signed(rs) < $signed(rt);
        data = '0;
        ovf  = 1'b0;
        unique case (op)
            OP_AND:  data = rs & rt;
            OP_OR:   data = rs | rt;
            OP_ADD: begin
                data = sum;
                ovf  = (rs[W-1] == rt[W-1]) && (sum[W-1] != rs[W-1]);
            end
            OP_SUB: begin
                data = diff;
                ovf  = (rs[W-1] != rt[W-1]) && (diff[W-1] != rs[W-1]);
            end
            OP_SLT:  data = {{(W-1){1'b0}}, lt};
            OP_NOR:  data = ~(rs | rt);
            OP_XOR:  data = rs ^ rt;
            OP_PASS: data = rs;
            default: data = '0;
        endcase
        zero = (data == '0);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered result slot under valid/ready back-pressure.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned OPW = OPW_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           REQ0_VALID,
    input  logic [OPW-1:0] REQ0_OP,
    input  logic [W-1:0]   REQ0_RS,
    input  logic [W-1:0]   REQ0_RT,
    output logic           REQ0_READY,
    input  logic           REQ1_VALID,
    input  logic [OPW-1:0] REQ1_OP,
    input  logic [W-1:0]   REQ1_RS,
    input  logic [W-1:0]   REQ1_RT,
    output logic           REQ1_READY,
    output logic           RSP_VALID,
    output logic           RSP_ID,
    output logic [W-1:0]   RSP_DATA,
    output logic           RSP_ZERO,
    output logic           RSP_OVF,
    input  logic           RSP_READY
);

    slot_state_e state_q, state_d;
    logic        last_q;
    logic        grant0, grant1, accept, free;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_rs, alu_rt, alu_data;
    logic           alu_zero, alu_ovf;

    assign RSP_VALID = (state_q == StFull);

    always_comb begin
        // On a tie the requester that did not win last time goes first.
        grant0     = REQ0_VALID & (~REQ1_VALID | last_q);
        grant1     = REQ1_VALID & (~REQ0_VALID | ~last_q);
        free       = slot_free(RSP_VALID, RSP_READY);
        REQ0_READY = ~RST & free & grant0;
        REQ1_READY = ~RST & free & grant1;
        accept     = REQ0_READY | REQ1_READY;
        alu_op     = grant1 ? REQ1_OP : REQ0_OP;
        alu_rs     = grant1 ? REQ1_RS : REQ0_RS;
        alu_rt     = grant1 ? REQ1_RT : REQ0_RT;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (RSP_READY && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    alu16_core #(
        .W   (W),
        .OPW (OPW)
    ) u_core (
        .op   (alu_op),
        .rs   (alu_rs),
        .rt   (alu_rt),
        .data (alu_data),
        .zero (alu_zero),
        .ovf  (alu_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StEmpty;
            last_q   <= 1'b1;
            RSP_ID   <= 1'b0;
            RSP_DATA <= '0;
            RSP_ZERO <= 1'b0;
            RSP_OVF  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q   <= grant1;
                RSP_ID   <= grant1;
                RSP_DATA <= alu_data;
                RSP_ZERO <= alu_zero;
                RSP_OVF  <= alu_ovf;
            end
        end
    end

endmodule
